// File: rtl/fft_pkg.sv
// Shared constants, register map and FSM encoding for the FFT sample loader.
package fft_pkg;
    localparam int FFT_N   = 16;
    localparam int FFT_GRP = 4;

    localparam logic [13:0] FFT_BASE = 14'h0A0;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DATA_RE = 2'd2;
    localparam logic [1:0] REG_DATA_IM = 2'd3;

    localparam int CTRL_START     = 0;
    localparam int CTRL_CLR_PTR   = 1;
    localparam int CTRL_CLR_FLAGS = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_DONE    = 2;
    localparam int STAT_OVERRUN = 3;
    localparam int STAT_CNT_LSB = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } fsm_state_t;

    function automatic logic [15:0] status_word(input logic busy, input logic full,
                                                input logic done, input logic ovr,
                                                input logic [4:0] cnt);
        logic [15:0] w;
        w                    = '0;
        w[STAT_BUSY]         = busy;
        w[STAT_FULL]         = full;
        w[STAT_DONE]         = done;
        w[STAT_OVERRUN]      = ovr;
        w[STAT_CNT_LSB +: 5] = cnt;
        return w;
    endfunction
endpackage

// File: rtl/fft_sample_loader_if.sv
// Peripheral bus plus group-operand stream of the FFT sample loader.
interface fft_sample_loader_if;
    logic [13:0]        per_addr;
    logic [15:0]        per_din;
    logic               per_en;
    logic [1:0]         per_we;
    logic [15:0]        per_dout;
    logic               grp_valid;
    logic               grp_ready;
    logic [1:0]         grp_idx;
    logic signed [15:0] grp_ar, grp_ai, grp_br, grp_bi;
    logic signed [15:0] grp_cr, grp_ci, grp_dr, grp_di;

    modport slave (
        input  per_addr, per_din, per_en, per_we, grp_ready,
        output per_dout, grp_valid, grp_idx,
        output grp_ar, grp_ai, grp_br, grp_bi, grp_cr, grp_ci, grp_dr, grp_di
    );

    modport master (
        output per_addr, per_din, per_en, per_we, grp_ready,
        input  per_dout, grp_valid, grp_idx,
        input  grp_ar, grp_ai, grp_br, grp_bi, grp_cr, grp_ci, grp_dr, grp_di
    );
endinterface

// File: rtl/fft_sample_buf.sv
// 16-entry complex sample store: one write port, strided 4-way gather (x[g], x[g+4], x[g+8], x[g+12]).
// Writes land at the clock edge; the gather is combinational with no backpressure of its own.
module fft_sample_buf
    import fft_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_re_i,
    input  logic               we_im_i,
    input  logic [3:0]         wr_idx_i,
    input  logic [15:0]        wr_dat_i,
    input  logic [1:0]         grp_i,
    output logic signed [15:0] ar_o,
    output logic signed [15:0] ai_o,
    output logic signed [15:0] br_o,
    output logic signed [15:0] bi_o,
    output logic signed [15:0] cr_o,
    output logic signed [15:0] ci_o,
    output logic signed [15:0] dr_o,
    output logic signed [15:0] di_o
);
    logic [15:0] re_q [FFT_N];
    logic [15:0] im_q [FFT_N];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FFT_N; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else begin
            if (we_re_i) re_q[wr_idx_i] <= wr_dat_i;
            if (we_im_i) im_q[wr_idx_i] <= wr_dat_i;
        end
    end

    // Index g + 4*k is simply {k, g} for a 16-entry buffer.
    assign ar_o = $signed(re_q[{2'd0, grp_i}]);
    assign ai_o = $signed(im_q[{2'd0, grp_i}]);
    assign br_o = $signed(re_q[{2'd1, grp_i}]);
    assign bi_o = $signed(im_q[{2'd1, grp_i}]);
    assign cr_o = $signed(re_q[{2'd2, grp_i}]);
    assign ci_o = $signed(im_q[{2'd2, grp_i}]);
    assign dr_o = $signed(re_q[{2'd3, grp_i}]);
    assign di_o = $signed(im_q[{2'd3, grp_i}]);
endmodule

// File: rtl/fft_sample_loader.sv
// Bus-loaded 16-sample buffer streamed to the radix-4 stage as four operand groups.
// START at edge N gives grp_valid after N; each group holds until grp_ready, one group per cycle when ready.
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter logic [13:0] BASE = FFT_BASE
) (
    input  logic               mclk,
    input  logic               puc_rst,
    fft_sample_loader_if.slave bus
);
    fsm_state_t  state_q;
    logic [3:0]  wr_ptr_q;
    logic [4:0]  count_q;
    logic [1:0]  grp_cnt_q;
    logic        done_q;
    logic        overrun_q;

    logic [1:0]  off;
    logic        sel, wr_en, rd_en, busy, full;
    logic        data_wr, data_ok, ctrl_wr, start_ok, hs, last_hs;

    assign off      = bus.per_addr[1:0];
    assign sel      = bus.per_en && (bus.per_addr[13:2] == BASE[13:2]);
    assign wr_en    = sel && (bus.per_we == 2'b11);
    assign rd_en    = sel && (bus.per_we == 2'b00);
    assign busy     = (state_q == ST_SEND);
    assign full     = (count_q == 5'(FFT_N));
    assign data_wr  = wr_en && ((off == REG_DATA_RE) || (off == REG_DATA_IM));
    assign data_ok  = data_wr && !full && !busy;
    assign ctrl_wr  = wr_en && (off == REG_CTRL);
    // CLR_PTR is applied before START, so a combined write can never launch.
    assign start_ok = ctrl_wr && bus.per_din[CTRL_START] && !bus.per_din[CTRL_CLR_PTR]
                      && !busy && full;
    assign hs       = busy && bus.grp_ready;
    assign last_hs  = hs && (grp_cnt_q == 2'(FFT_GRP - 1));

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            grp_cnt_q <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (data_wr && !data_ok) overrun_q <= 1'b1;
            if (data_ok && (off == REG_DATA_IM)) begin
                wr_ptr_q <= wr_ptr_q + 4'd1;
                count_q  <= count_q + 5'd1;
            end
            if (ctrl_wr && bus.per_din[CTRL_CLR_FLAGS]) begin
                done_q    <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (ctrl_wr && bus.per_din[CTRL_CLR_PTR] && !busy) begin
                wr_ptr_q <= '0;
                count_q  <= '0;
            end
            if (start_ok) begin
                state_q   <= ST_SEND;
                done_q    <= 1'b0;
                grp_cnt_q <= '0;
            end
            if (hs) begin
                grp_cnt_q <= grp_cnt_q + 2'd1;
                if (last_hs) begin
                    state_q  <= ST_IDLE;
                    done_q   <= 1'b1;
                    count_q  <= '0;
                    wr_ptr_q <= '0;
                end
            end
        end
    end

    assign bus.per_dout  = (rd_en && (off == REG_STATUS))
                           ? status_word(busy, full, done_q, overrun_q, count_q) : 16'h0000;
    assign bus.grp_valid = busy;
    assign bus.grp_idx   = grp_cnt_q;

    fft_sample_buf u_buf (
        .clk_i    (mclk),
        .rst_i    (puc_rst),
        .we_re_i  (data_ok && (off == REG_DATA_RE)),
        .we_im_i  (data_ok && (off == REG_DATA_IM)),
        .wr_idx_i (wr_ptr_q),
        .wr_dat_i (bus.per_din),
        .grp_i    (grp_cnt_q),
        .ar_o     (bus.grp_ar),
        .ai_o     (bus.grp_ai),
        .br_o     (bus.grp_br),
        .bi_o     (bus.grp_bi),
        .cr_o     (bus.grp_cr),
        .ci_o     (bus.grp_ci),
        .dr_o     (bus.grp_dr),
        .di_o     (bus.grp_di)
    );
endmodule

// File: doc/fft_sample_loader.md
# fft_sample_loader

Peripheral-bus front end that feeds the 16-point FFT datapath. The CPU writes 16 complex samples through the openMSP430 peripheral bus into a local buffer, then starts the transfer. The block streams the samples to the radix-4 butterfly stage as four groups of four complex operands over a valid/ready handshake. It is the writer-side counterpart of the FFT result peripheral.

## Interface
- BASE, 14'h0A0, word address of CTRL; the block decodes BASE..BASE+3.
- mclk  in  1  system clock
- puc_rst  in  1  asynchronous, active-high reset
- per_addr  in  14  peripheral word address
- per_din  in  16  write data
- per_en  in  1  bus cycle enable
- per_we  in  2  byte write strobes
- per_dout  out  16  read data; 0 when not selected
- grp_valid  out  1  group operands valid
- grp_ready  in  1  datapath accepts group
- grp_idx  out  2  group number g (0..3)
- grp_ar, grp_ai, grp_br, grp_bi, grp_cr, grp_ci, grp_dr, grp_di  out  16 each  signed operands x[g], x[g+4], x[g+8], x[g+12], real/imag

## Operation
- Registers (word offsets from BASE):
  - 0 CTRL (write-only): bit0 START, bit1 CLR_PTR, bit2 CLR_FLAGS.
  - 1 STATUS (read-only): bit0 busy, bit1 full, bit2 done, bit3 overrun, bits[8:4] count (0..16), other bits 0.
  - 2 DATA_RE (write-only).
  - 3 DATA_IM (write-only).
- Write = per_en & per_we==2'b11 & address hit. Byte writes (per_we 01/10) are ignored. Read = per_en & per_we==0.
- DATA_RE write stores the real part at wr_ptr. DATA_IM write stores the imaginary part at wr_ptr, then wr_ptr++ and count++.
- full = (count==16). A DATA_* write while full or busy is dropped and sets overrun.
- CLR_PTR sets wr_ptr and count to 0. It is ignored while busy.
- CLR_FLAGS clears done and overrun.
- Bits of one CTRL write are applied in this order: CLR_FLAGS, CLR_PTR, START.
- FSM has two states, IDLE and SEND.
  - IDLE to SEND: START written while full. This also clears done and sets grp_cnt=0.
  - START while not full, or while in SEND, is ignored with no flag set.
  - SEND: grp_valid=1, grp_idx=grp_cnt, and operands are gathered from the buffer at indices g, g+4, g+8, g+12.
  - On grp_valid & grp_ready: grp_cnt++.
  - The handshake on g=3 returns the FSM to IDLE, sets done, and clears count and wr_ptr.
- busy = (state==SEND).
- The buffer is unchanged during SEND because writes are blocked, so operands are stable while grp_valid is high.
- No arithmetic on samples; values pass through bit-exact.
- Reset values: state IDLE, buffer all 0, wr_ptr/count/grp_cnt 0, flags 0. Resulting outputs: grp_valid 0, grp_idx 0, all operands 0, per_dout 0.
- Reset mid-SEND aborts immediately and the buffer contents are lost.

## Timing
- Register writes take effect at the mclk edge ending the bus cycle.
- per_dout is combinational: STATUS is visible in the same cycle as the read.
- A START write accepted at edge N gives grp_valid=1 in the cycle after edge N.
- Each group is held until a handshake. With grp_ready tied high, the four groups take four consecutive cycles.
- After the g=3 handshake at edge M, grp_valid=0 and done=1 starting the cycle after M.
- grp_valid and grp_idx are decoded from registered state only; they do not depend combinationally on grp_ready.
- Operands are a combinational gather from registered buffer entries.
- A STATUS read in the same cycle as a state-changing edge returns the pre-edge value.

## Structure
- Package fft_pkg holds:
  - FFT_N=16 and FFT_GRP=4;
  - register offsets CTRL/STATUS/DATA_RE/DATA_IM;
  - CTRL and STATUS bit positions;
  - the two-state FSM enum.
- Sub-module fft_sample_buf: a 16-entry by {re,im} register file with a single write port and a 4-way strided gather read indexed by grp_cnt.

## Test plan
- Normal load and send:
  - Stimulus: write samples k=0..15 as re=k, im=-k, read STATUS, write START, hold grp_ready=1.
  - Response: STATUS reads 0x0102 before START. Groups are g0 {0,4,8,12}, g1 {1,5,9,13}, g2 {2,6,10,14}, g3 {3,7,11,15}, with matching negated imaginary parts, on 4 consecutive cycles. STATUS then reads 0x0004.
- Backpressure:
  - Stimulus: full load, START, grp_ready low for 5 cycles during g=1.
  - Response: grp_idx holds at 1 and operands are held stable; the transfer completes on the 4th handshake.
- Premature START and byte write:
  - Stimulus: load 15 samples, then START. Separately, write DATA_RE with per_we=01.
  - Response: busy stays 0, count is 15, and the stored value is unchanged.
- Overrun:
  - Stimulus: write DATA_IM during SEND, and again when full in IDLE.
  - Response: overrun=1 and the buffer is unchanged. CLR_FLAGS returns STATUS bit3 to 0.
- Reset mid-transfer:
  - Stimulus: assert puc_rst during g=2.
  - Response: grp_valid=0, all operands 0, per_dout=0, STATUS=0 after release. A re-load and send then works normally.
